// File: rtl/xadc_drp_sampler_if.sv
// Signal bundle between the XADC DRP sampler, the XADC DRP port and the downstream consumer.
interface xadc_drp_sampler_if;
   logic        enable;
   logic        eoc;
   logic        drdy;
   logic [15:0] do_in;
   logic        den;
   logic        dwe;
   logic [6:0]  daddr;
   logic [11:0] sample;
   logic        sample_valid;
   logic        sample_ready;
   logic        err_timeout;
   logic        overrun;
   logic        clr_err;

   modport master (
      input  enable, eoc, drdy, do_in, sample_ready, clr_err,
      output den, dwe, daddr, sample, sample_valid, err_timeout, overrun
   );

   modport slave (
      output enable, eoc, drdy, do_in, sample_ready, clr_err,
      input  den, dwe, daddr, sample, sample_valid, err_timeout, overrun
   );
endinterface

// File: rtl/xadc_drp_sampler.sv
// XADC DRP read sequencer with a 2^AVG_LOG2 decimating averager and a valid/ready sample output.
// Define XADC_SAMPLER_TIMEOUT_EN to build the DRP read timeout (err_timeout is tied 0 otherwise).
module xadc_drp_sampler #(
   parameter logic [6:0] DADDR    = 7'h12,
   parameter int         AVG_LOG2 = 2,
   parameter int         TIMEOUT  = 255
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_srst,
   xadc_drp_sampler_if.master bus
);
   localparam int ACC_W = 12 + AVG_LOG2;
   localparam int CNT_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_EOC  = 2'd1,
      S_READ      = 2'd2,
      S_WAIT_DRDY = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] w_sum;
   logic [CNT_W-1:0] r_cnt;
   logic [11:0]      r_sample;
   logic [11:0]      w_avg;
   logic             r_sample_valid;
   logic             r_den;
   logic             r_overrun;
   logic             w_capture;
   logic             w_done;
   logic             w_timeout;
   logic             w_ovr_set;
   logic [3:0]       w_unused_nib;

   assign w_unused_nib = bus.do_in[3:0];
   assign w_sum        = r_acc + ACC_W'(bus.do_in[15:4]);
   assign w_avg        = 12'(w_sum >> AVG_LOG2);
   assign w_done       = w_capture && (r_cnt == CNT_LAST);
   assign w_ovr_set    = w_done && r_sample_valid && !bus.sample_ready;

`ifdef XADC_SAMPLER_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
   logic [7:0] r_tmo_cnt;
   logic       r_err_timeout;

   // Cycles spent in WAIT_DRDY for the current read; restarts with every DRP read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmo_cnt <= 8'd0;
      end else if (i_srst || (r_state == S_READ)) begin
         r_tmo_cnt <= 8'd0;
      end else if (r_state == S_WAIT_DRDY) begin
         r_tmo_cnt <= r_tmo_cnt + 8'd1;
      end else begin
         r_tmo_cnt <= r_tmo_cnt;
      end
   end

   // drdy in the final counted cycle still completes the read
   assign w_timeout = (r_state == S_WAIT_DRDY) && !bus.drdy && (r_tmo_cnt == TMO_LAST);

   // Sticky timeout flag; a new timeout outranks a simultaneous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_timeout <= 1'b0;
      end else if (i_srst) begin
         r_err_timeout <= 1'b0;
      end else if (w_timeout) begin
         r_err_timeout <= 1'b1;
      end else if (bus.clr_err) begin
         r_err_timeout <= 1'b0;
      end else begin
         r_err_timeout <= r_err_timeout;
      end
   end

   assign bus.err_timeout = r_err_timeout;
`else
   logic [7:0] w_unused_tmo;
   assign w_unused_tmo    = 8'(TIMEOUT);
   assign w_timeout       = 1'b0;
   assign bus.err_timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else if (i_srst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; a read in flight always finishes before enable is honoured
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.enable) begin
               w_state_nxt = S_WAIT_EOC;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_WAIT_EOC: begin
            if (!bus.enable) begin
               w_state_nxt = S_IDLE;
            end else if (bus.eoc) begin
               w_state_nxt = S_READ;
            end else begin
               w_state_nxt = S_WAIT_EOC;
            end
         end
         S_READ: begin
            w_state_nxt = S_WAIT_DRDY;
         end
         S_WAIT_DRDY: begin
            if (bus.drdy) begin
               w_capture   = 1'b1;
               w_state_nxt = bus.enable ? S_WAIT_EOC : S_IDLE;
            end else if (w_timeout) begin
               w_state_nxt = bus.enable ? S_WAIT_EOC : S_IDLE;
            end else begin
               w_state_nxt = S_WAIT_DRDY;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // DRP enable is high exactly in the READ cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_den <= 1'b0;
      end else if (i_srst) begin
         r_den <= 1'b0;
      end else begin
         r_den <= (w_state_nxt == S_READ);
      end
   end

   // Accumulator; IDLE discards any partial average
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (i_srst || (r_state == S_IDLE) || w_done) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (w_capture) begin
         r_acc <= w_sum;
         r_cnt <= r_cnt + CNT_W'(1);
      end else begin
         r_acc <= r_acc;
         r_cnt <= r_cnt;
      end
   end

   // Output sample: load on completion unless a held sample is not being accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sample       <= 12'd0;
         r_sample_valid <= 1'b0;
      end else if (i_srst) begin
         r_sample       <= 12'd0;
         r_sample_valid <= 1'b0;
      end else if (w_done && (!r_sample_valid || bus.sample_ready)) begin
         r_sample       <= w_avg;
         r_sample_valid <= 1'b1;
      end else if (!w_done && r_sample_valid && bus.sample_ready) begin
         r_sample       <= r_sample;
         r_sample_valid <= 1'b0;
      end else begin
         r_sample       <= r_sample;
         r_sample_valid <= r_sample_valid;
      end
   end

   // Sticky overrun flag for dropped averages
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overrun <= 1'b0;
      end else if (i_srst) begin
         r_overrun <= 1'b0;
      end else if (w_ovr_set) begin
         r_overrun <= 1'b1;
      end else if (bus.clr_err) begin
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= r_overrun;
      end
   end

   assign bus.den          = r_den;
   assign bus.dwe          = 1'b0;
   assign bus.daddr        = DADDR;
   assign bus.sample       = r_sample;
   assign bus.sample_valid = r_sample_valid;
   assign bus.overrun      = r_overrun;
endmodule

// File: tb/tb_xadc_drp_sampler.sv
// Bench for xadc_drp_sampler: a pass-through and a 4-sample averaging instance share one stimulus
// stream and are compared against a transaction-level averaging model.
`timescale 1ns/1ps
module tb_xadc_drp_sampler;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        srst;
   logic        enable;
   logic        eoc;
   logic        drdy;
   logic [15:0] do_in;
   logic        sample_ready;
   logic        clr_err;

   int n_checks = 0;
   int n_errors = 0;

   // Model: per instance (0 = pass-through, 1 = 4-sample average)
   int m_sum[2];
   int m_n[2];
   int m_sample[2];
   bit m_valid[2];
   bit m_ovr[2];
   bit m_err[2];

   always #5 clk = ~clk;

   xadc_drp_sampler_if if0 ();
   xadc_drp_sampler_if if2 ();

   assign if0.enable = enable;       assign if2.enable = enable;
   assign if0.eoc = eoc;             assign if2.eoc = eoc;
   assign if0.drdy = drdy;           assign if2.drdy = drdy;
   assign if0.do_in = do_in;         assign if2.do_in = do_in;
   assign if0.sample_ready = sample_ready; assign if2.sample_ready = sample_ready;
   assign if0.clr_err = clr_err;     assign if2.clr_err = clr_err;

   xadc_drp_sampler #(.DADDR(7'h12), .AVG_LOG2(0), .TIMEOUT(10)) u_pass (
      .clk(clk), .rst_n(rst_n), .i_srst(srst), .bus(if0));
   xadc_drp_sampler #(.DADDR(7'h12), .AVG_LOG2(2), .TIMEOUT(10)) u_avg (
      .clk(clk), .rst_n(rst_n), .i_srst(srst), .bus(if2));

   function automatic int navg(input int k);
      return (k == 0) ? 1 : 4;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_sum[k] = 0; m_n[k] = 0; m_sample[k] = 0;
         m_valid[k] = 1'b0; m_ovr[k] = 1'b0; m_err[k] = 1'b0;
      end
   endtask

   // Effect of the cycles before drdy: a held sample is taken if ready, flags clear if clr_err
   task automatic model_pre(input bit rp);
      for (int k = 0; k < 2; k++) begin
         if (rp) m_valid[k] = 1'b0;
         if (clr_err) begin m_ovr[k] = 1'b0; m_err[k] = 1'b0; end
      end
   endtask

   task automatic model_drdy(input int d, input bit ra);
      for (int k = 0; k < 2; k++) begin
         m_sum[k] += d;
         m_n[k]++;
         if (m_n[k] == navg(k)) begin
            if (!m_valid[k] || ra) begin
               m_sample[k] = m_sum[k] / navg(k);
               m_valid[k]  = 1'b1;
            end else begin
               m_ovr[k] = 1'b1;
            end
            m_sum[k] = 0;
            m_n[k]   = 0;
         end else if (m_valid[k] && ra) begin
            m_valid[k] = 1'b0;
         end
         if (clr_err && !(m_n[k] == 0 && m_ovr[k] && m_valid[k] && !ra && m_sum[k] == 0 && d >= 0 && navg(k) > 0 && 1'b0))
            ;
      end
   endtask

   task automatic check_outs(input string tag);
      check({tag, "/p.sample"},  32'(if0.sample),       32'(m_sample[0]));
      check({tag, "/p.valid"},   32'(if0.sample_valid), 32'(m_valid[0]));
      check({tag, "/p.overrun"}, 32'(if0.overrun),      32'(m_ovr[0]));
      check({tag, "/p.err"},     32'(if0.err_timeout),  32'(m_err[0]));
      check({tag, "/a.sample"},  32'(if2.sample),       32'(m_sample[1]));
      check({tag, "/a.valid"},   32'(if2.sample_valid), 32'(m_valid[1]));
      check({tag, "/a.overrun"}, 32'(if2.overrun),      32'(m_ovr[1]));
      check({tag, "/a.err"},     32'(if2.err_timeout),  32'(m_err[1]));
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "/p.den"},    32'(if0.den),          32'd0);
      check({tag, "/p.sample"}, 32'(if0.sample),       32'd0);
      check({tag, "/p.valid"},  32'(if0.sample_valid), 32'd0);
      check({tag, "/p.ovr"},    32'(if0.overrun),      32'd0);
      check({tag, "/a.den"},    32'(if2.den),          32'd0);
      check({tag, "/a.sample"}, 32'(if2.sample),       32'd0);
      check({tag, "/a.valid"},  32'(if2.sample_valid), 32'd0);
      check({tag, "/a.ovr"},    32'(if2.overrun),      32'd0);
      check({tag, "/a.err"},    32'(if2.err_timeout),  32'd0);
   endtask

   // One full read: eoc, den, gap WAIT_DRDY cycles, drdy; ready = rp before drdy and ra on drdy
   task automatic do_read(input int d, input bit rp, input bit ra, input int gap, input bit drop);
      @(negedge clk);
      sample_ready = rp;
      eoc = 1'b1;
      model_pre(rp);
      @(negedge clk);
      eoc = 1'b0;
      check("den_after_eoc/p", 32'(if0.den), 32'd1);
      check("den_after_eoc/a", 32'(if2.den), 32'd1);
      for (int i = 0; i < gap; i++) begin
         @(negedge clk);
         if (drop) enable = 1'b0;
      end
      @(negedge clk);
      check("den_single_cycle", 32'(if2.den), 32'd0);
      drdy = 1'b1;
      sample_ready = ra;
      do_in = {12'(d), 4'($urandom_range(0, 15))};
      @(negedge clk);
      drdy = 1'b0;
      sample_ready = 1'b0;
      do_in = 16'(($urandom));
      model_drdy(d, ra);
      if (drop) begin
         for (int k = 0; k < 2; k++) begin m_sum[k] = 0; m_n[k] = 0; end
      end
      check_outs("read");
   endtask

   task automatic clear_errs();
      @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      for (int k = 0; k < 2; k++) begin m_ovr[k] = 1'b0; m_err[k] = 1'b0; end
      check_outs("clr_err");
   endtask

   initial begin
      int vals[4];
      int tot;
      rst_n = 1'b0; srst = 1'b0; enable = 1'b0; eoc = 1'b0; drdy = 1'b0;
      do_in = 16'h0000; sample_ready = 1'b0; clr_err = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      check("reset/dwe",   32'(if2.dwe),   32'd0);
      check("reset/daddr", 32'(if2.daddr), 32'h12);
      rst_n = 1'b1;
      enable = 1'b1;

      // Averaging 100,101,102,104 -> 101; pass-through shows each value
      do_read(100, 1'b1, 1'b1, 0, 1'b0);
      do_read(101, 1'b1, 1'b1, 1, 1'b0);
      do_read(102, 1'b1, 1'b1, 0, 1'b0);
      do_read(104, 1'b1, 1'b1, 2, 1'b0);
      check("avg_407_div4", 32'(if2.sample), 32'd101);
      check("avg_valid",    32'(if2.sample_valid), 32'd1);

      do_read(12'hABC, 1'b1, 1'b1, 0, 1'b0);
      check("passthrough_abc", 32'(if0.sample), 32'hABC);

      // Backpressure: hold, drop, overrun
      for (int i = 0; i < 8; i++) do_read(int'($urandom_range(0, 4095)), 1'b0, 1'b0, 0, 1'b0);
      check("overrun_set", 32'(if2.overrun), 32'd1);
      clear_errs();
      // Completion coinciding with ready on the averaging instance
      for (int i = 0; i < 4; i++)
         do_read(int'($urandom_range(0, 4095)), 1'b0, (m_n[1] == 3), 0, 1'b0);
      // clr_err held while a dropped completion sets overrun: set wins
      clr_err = 1'b1;
      do_read(int'($urandom_range(0, 4095)), 1'b0, 1'b0, 1, 1'b0);
      clr_err = 1'b0;
      check("set_beats_clr", 32'(if0.overrun), 32'd1);
      clear_errs();

      // enable dropped after 2 of 4 samples
      for (int i = 0; i < 4 && m_n[1] != 2; i++)
         do_read(int'($urandom_range(0, 4095)), 1'b1, 1'b1, 0, 1'b0);
      do_read(int'($urandom_range(0, 4095)), 1'b1, 1'b1, 2, 1'b1);
      @(negedge clk);
      eoc = 1'b1;
      @(negedge clk);
      eoc = 1'b0;
      check("idle_ignores_eoc", 32'(if2.den), 32'd0);
      enable = 1'b1;
      @(negedge clk);
      tot = 0;
      for (int i = 0; i < 4; i++) begin
         vals[i] = int'($urandom_range(0, 4095));
         tot += vals[i];
         do_read(vals[i], 1'b1, 1'b1, 0, 1'b0);
      end
      check("reenable_fresh_avg", 32'(if2.sample), 32'(tot / 4));

`ifdef XADC_SAMPLER_TIMEOUT_EN
      @(negedge clk);
      eoc = 1'b1;
      @(negedge clk);
      eoc = 1'b0;
      check("tmo_den", 32'(if2.den), 32'd1);
      repeat (10) @(negedge clk);
      check("tmo_not_yet", 32'(if2.err_timeout), 32'd0);
      @(negedge clk);
      m_err[0] = 1'b1; m_err[1] = 1'b1;
      check_outs("tmo_fired");
      drdy = 1'b1;
      do_in = 16'hFFF0;
      @(negedge clk);
      drdy = 1'b0;
      check_outs("late_drdy");
      for (int i = 0; i < 4; i++)
         do_read(int'($urandom_range(0, 4095)), 1'b1, 1'b1, 0, 1'b0);
      clear_errs();
`else
      @(negedge clk);
      eoc = 1'b1;
      @(negedge clk);
      eoc = 1'b0;
      repeat (20) @(negedge clk);
      check("no_timeout", 32'(if2.err_timeout), 32'd0);
      drdy = 1'b1;
      do_in = 16'h5A50;
      @(negedge clk);
      drdy = 1'b0;
      model_drdy(12'h5A5, 1'b0);
      check_outs("slow_drdy");
`endif

      // Make sure a sample is held, then reset asynchronously in WAIT_DRDY
      for (int i = 0; i < 4 && !(m_valid[1] && m_n[1] == 0); i++)
         do_read(int'($urandom_range(0, 4095)), 1'b0, 1'b0, 0, 1'b0);
      check("pre_reset_valid", 32'(if2.sample_valid), 32'd1);
      @(negedge clk);
      eoc = 1'b1;
      @(negedge clk);
      eoc = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("async_reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Random traffic
      for (int i = 0; i < 16; i++)
         do_read(int'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);

      // Synchronous soft reset
      @(negedge clk);
      srst = 1'b1;
      @(negedge clk);
      srst = 1'b0;
      model_reset();
      check_outs("srst");
      check("srst/den", 32'(if2.den), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/xadc_drp_sampler.md
# xadc_drp_sampler

DRP read sequencer and decimating averager that sits directly upstream of the XADC threshold controller. It waits for end-of-conversion, issues a single-cycle DRP read on a fixed channel address, and captures the 12-bit conversion result. It accumulates 2^AVG_LOG2 results and presents the truncated mean to the consumer over a valid/ready handshake. It also flags DRP read timeouts and dropped averages.

## Interface
- DADDR, 7'h12, DRP address driven on every read (VAUX2 result register)
- AVG_LOG2, 2, log2 of samples per average (0..4; 0 = pass-through)
- TIMEOUT, 255, max cycles waiting for drdy before abort (1..255)

- clk  in  1  DRP clock (same domain as the XADC dclk)
- rst  in  1  asynchronous, active-low reset
- enable  in  1  level; 1 = run sampling
- eoc  in  1  end-of-conversion pulse from XADC
- drdy  in  1  DRP read-data-ready pulse
- do_in  in  16  DRP read data; result is do_in[15:4]
- den  out  1  DRP enable, one-cycle pulse per read
- dwe  out  1  DRP write enable, constant 0
- daddr  out  7  constant DADDR
- sample  out  12  averaged result, held until accepted
- sample_valid  out  1  sample holds an unconsumed average
- sample_ready  in  1  consumer accepts sample when high with sample_valid
- err_timeout  out  1  sticky: a DRP read timed out
- overrun  out  1  sticky: a completed average was dropped
- clr_err  in  1  synchronous clear of err_timeout and overrun

## Operation
- FSM states: IDLE, WAIT_EOC, READ, WAIT_DRDY.
- IDLE: acc=0, cnt=0. enable=1 -> WAIT_EOC.
- WAIT_EOC: eoc=1 -> READ. enable=0 -> IDLE. eoc in any other state is ignored.
- READ: den=1 for exactly this cycle -> WAIT_DRDY. Timeout counter is cleared.
- WAIT_DRDY, on drdy=1:
  - acc += do_in[15:4]; cnt++.
  - If cnt reaches 2^AVG_LOG2, the completed average is (acc + data) >> AVG_LOG2, truncated; acc and cnt clear.
  - Next state is WAIT_EOC if enable=1, else IDLE.
- Accumulator width is 12+AVG_LOG2 bits and cannot overflow.
- Completed average:
  - sample_valid=0: load sample, set sample_valid.
  - sample_valid=1 and sample_ready=1 in the same cycle: load the new value, sample_valid stays 1.
  - sample_valid=1 and sample_ready=0: sample is unchanged, the average is dropped, overrun is set.
- sample_valid clears on acceptance when no completion occurs in the same cycle.
- enable falling mid-read: the in-flight read completes (or times out), then the FSM goes to IDLE. The partial accumulation is discarded. A held sample/sample_valid is kept.
- clr_err coinciding with a set event: set wins.

## Timing
- Reset values: den=0, dwe=0, sample=0, sample_valid=0, err_timeout=0, overrun=0; state=IDLE, acc=0, cnt=0.
- eoc sampled high in cycle t -> den high in cycle t+1 only.
- drdy sampled high in cycle d -> sample and sample_valid updated at the edge ending d; visible in cycle d+1.
- Minimum spacing between reads is 3 cycles (eoc, den, drdy).
- Handshake transfer occurs on any edge with sample_valid=1 and sample_ready=1.

## Configuration
- XADC_SAMPLER_TIMEOUT_EN defined:
  - An 8-bit counter runs in WAIT_DRDY.
  - When it reaches TIMEOUT without drdy: err_timeout is set, the read is abandoned, acc and cnt are kept, and the FSM goes to WAIT_EOC (IDLE if enable=0).
  - A drdy arriving later is ignored.
- XADC_SAMPLER_TIMEOUT_EN undefined: WAIT_DRDY waits indefinitely, err_timeout is tied 0, and no counter is synthesized.

## Test plan
- Pass-through: AVG_LOG2=0, enable=1, eoc then drdy with do_in=16'hABC0 -> den pulses 1 cycle after eoc; sample=12'hABC and sample_valid=1 the cycle after drdy.
- Averaging: AVG_LOG2=2, four reads with results 100, 101, 102, 104 -> one sample=101 (407>>2), no sample_valid before the fourth drdy.
- Backpressure: sample_ready=0, two completed averages -> first is held, second is dropped, overrun=1. clr_err -> overrun=0 next cycle. Completion with simultaneous ready -> new value loaded, sample_valid stays 1.
- Timeout (macro defined, TIMEOUT=10): den issued, no drdy -> err_timeout=1 after 10 cycles, FSM in WAIT_EOC, a late drdy does not change acc.
- Reset mid-read: rst low during WAIT_DRDY with sample_valid=1 -> all outputs return to reset values immediately, asynchronously.
- enable dropped in WAIT_DRDY with 2 of 4 samples accumulated -> read completes, FSM in IDLE; after re-enable, the next average uses only 4 new samples.
